// File: rtl/ysyx_210544_cmt_stage_pkg.sv
// Shared commit-stage definitions: bus widths, FSM encodings and the trap opcode.
package ysyx_210544_cmt_stage_pkg;

  localparam int BUS_64   = 64;
  localparam int BUS_32   = 32;
  localparam int BUS_RIDX = 5;

  localparam logic [BUS_32-1:0] CMT_TRAP_INST = 32'h0000_006b;
  localparam logic [BUS_RIDX-1:0] CMT_A0_IDX  = 5'd10;

  typedef enum logic [1:0] {
    CMT_IDLE  = 2'd0,
    CMT_ACK   = 2'd1,
    CMT_GUARD = 2'd2,
    CMT_HALT  = 2'd3
  } cmt_state_e;

endpackage

// File: rtl/ysyx_210544_cmt_stage_counters.sv
// Free-running cycle counter plus retired-instruction counter; both wrap silently.
module ysyx_210544_cmt_counters #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ret_inc_i,
  output logic [CNT_W-1:0] cycle_o,
  output logic [CNT_W-1:0] instret_o
);

  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  always_comb begin
    cycle_d   = cycle_q + CNT_W'(1);
    instret_d = ret_inc_i ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_o   = cycle_q;
  assign instret_o = instret_q;

endmodule

// File: rtl/ysyx_210544_cmt_stage.sv
// Commit stage: accepts one writeback packet per req/ack, writes the RF,
// emits the difftest record, counts cycles/instret and halts on the trap opcode.
module ysyx_210544_cmt_stage
  import ysyx_210544_cmt_stage_pkg::*;
#(
  parameter logic [31:0] TRAP_INST = CMT_TRAP_INST,
  parameter int          CNT_W     = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_cmt_writebacked_req,
  output logic                o_cmt_writebacked_ack,
  input  logic [BUS_64-1:0]   i_cmt_pc,
  input  logic [BUS_32-1:0]   i_cmt_inst,
  input  logic [BUS_RIDX-1:0] i_cmt_rd,
  input  logic                i_cmt_rd_wen,
  input  logic [BUS_64-1:0]   i_cmt_rd_wdata,
  input  logic                i_cmt_skipcmt,
  input  logic [BUS_32-1:0]   i_cmt_intrNo,
  output logic                o_cmt_rf_wen,
  output logic [BUS_RIDX-1:0] o_cmt_rf_waddr,
  output logic [BUS_64-1:0]   o_cmt_rf_wdata,
  output logic                o_cmt_valid,
  output logic [BUS_64-1:0]   o_cmt_pc,
  output logic [BUS_32-1:0]   o_cmt_inst,
  output logic                o_cmt_skip,
  output logic [BUS_32-1:0]   o_cmt_intrNo,
  output logic [CNT_W-1:0]    o_cmt_cycle,
  output logic [CNT_W-1:0]    o_cmt_instret,
  output logic                o_cmt_halt,
  output logic [BUS_64-1:0]   o_cmt_halt_code
);

  cmt_state_e          state_q;
  logic                ack_q, valid_q, skip_q, rf_wen_q, halt_q;
  logic [BUS_64-1:0]   pc_q, rf_wdata_q, a0_q, halt_code_q;
  logic [BUS_32-1:0]   inst_q, intr_q;
  logic [BUS_RIDX-1:0] rf_waddr_q;

  logic wen_ok;
  logic a0_wr;
  assign wen_ok = i_cmt_rd_wen && (i_cmt_rd != '0) && (i_cmt_intrNo == '0);
  assign a0_wr  = rf_wen_q && (rf_waddr_q == CMT_A0_IDX);

  // The output registers double as the packet holding registers: they are
  // loaded on capture, live for the single ACK cycle, then cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= CMT_IDLE;
      ack_q       <= 1'b0;
      valid_q     <= 1'b0;
      pc_q        <= '0;
      inst_q      <= '0;
      skip_q      <= 1'b0;
      intr_q      <= '0;
      rf_wen_q    <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      a0_q        <= '0;
      halt_q      <= 1'b0;
      halt_code_q <= '0;
    end else begin
      case (state_q)
        CMT_IDLE: if (i_cmt_writebacked_req) begin
          state_q    <= CMT_ACK;
          ack_q      <= 1'b1;
          valid_q    <= 1'b1;
          pc_q       <= i_cmt_pc;
          inst_q     <= i_cmt_inst;
          skip_q     <= i_cmt_skipcmt;
          intr_q     <= i_cmt_intrNo;
          rf_wen_q   <= wen_ok;
          rf_waddr_q <= wen_ok ? i_cmt_rd : '0;
          rf_wdata_q <= wen_ok ? i_cmt_rd_wdata : '0;
        end
        CMT_ACK: begin
          ack_q      <= 1'b0;
          valid_q    <= 1'b0;
          pc_q       <= '0;
          inst_q     <= '0;
          skip_q     <= 1'b0;
          intr_q     <= '0;
          rf_wen_q   <= 1'b0;
          rf_waddr_q <= '0;
          rf_wdata_q <= '0;
          if (a0_wr) a0_q <= rf_wdata_q;
          // The trap's own a0 write must be visible in the halt code.
          if (inst_q == TRAP_INST) begin
            state_q     <= CMT_HALT;
            halt_q      <= 1'b1;
            halt_code_q <= a0_wr ? rf_wdata_q : a0_q;
          end else begin
            state_q <= CMT_GUARD;
          end
        end
        CMT_GUARD: state_q <= CMT_IDLE;
        CMT_HALT:  state_q <= CMT_HALT;
        default:   state_q <= CMT_IDLE;
      endcase
    end
  end

  ysyx_210544_cmt_counters #(.CNT_W(CNT_W)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .ret_inc_i ((state_q == CMT_ACK) && (intr_q == '0)),
    .cycle_o   (o_cmt_cycle),
    .instret_o (o_cmt_instret)
  );

  assign o_cmt_writebacked_ack = ack_q;
  assign o_cmt_valid           = valid_q;
  assign o_cmt_pc              = pc_q;
  assign o_cmt_inst            = inst_q;
  assign o_cmt_skip            = skip_q;
  assign o_cmt_intrNo          = intr_q;
  assign o_cmt_rf_wen          = rf_wen_q;
  assign o_cmt_rf_waddr        = rf_waddr_q;
  assign o_cmt_rf_wdata        = rf_wdata_q;
  assign o_cmt_halt            = halt_q;
  assign o_cmt_halt_code       = halt_code_q;

endmodule

// File: tb/tb_ysyx_210544_cmt_stage.sv
// Directed bench for the commit stage: vector table plus hand-written corner sequences.
module tb_ysyx_210544_cmt_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        ack;
  logic [63:0] pc = '0;
  logic [31:0] inst = '0;
  logic [4:0]  rd = '0;
  logic        rd_wen = 1'b0;
  logic [63:0] rd_wdata = '0;
  logic        skip = 1'b0;
  logic [31:0] intr = '0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        valid;
  logic [63:0] cpc;
  logic [31:0] cinst;
  logic        cskip;
  logic [31:0] cintr;
  logic [63:0] cycle, instret;
  logic        halt;
  logic [63:0] halt_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_210544_cmt_stage dut (
    .clk(clk), .rst(rst),
    .i_cmt_writebacked_req(req), .o_cmt_writebacked_ack(ack),
    .i_cmt_pc(pc), .i_cmt_inst(inst), .i_cmt_rd(rd), .i_cmt_rd_wen(rd_wen),
    .i_cmt_rd_wdata(rd_wdata), .i_cmt_skipcmt(skip), .i_cmt_intrNo(intr),
    .o_cmt_rf_wen(rf_wen), .o_cmt_rf_waddr(rf_waddr), .o_cmt_rf_wdata(rf_wdata),
    .o_cmt_valid(valid), .o_cmt_pc(cpc), .o_cmt_inst(cinst), .o_cmt_skip(cskip),
    .o_cmt_intrNo(cintr), .o_cmt_cycle(cycle), .o_cmt_instret(instret),
    .o_cmt_halt(halt), .o_cmt_halt_code(halt_code)
  );

  typedef struct {
    string       name;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] wdata;
    logic        skip;
    logic [31:0] intr;
    logic        exp_rf_wen;
    logic [4:0]  exp_waddr;
    logic [63:0] exp_wdata;
    logic [63:0] exp_ret_inc;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drives one packet, waits (bounded) for ack, checks the ACK-cycle record
  // and the cleared outputs plus instret step in the following cycle.
  task automatic commit(input vec_t v);
    logic [63:0] ret0;
    int lat;
    logic seen;
    ret0 = instret;
    pc = v.pc; inst = v.inst; rd = v.rd; rd_wen = v.wen;
    rd_wdata = v.wdata; skip = v.skip; intr = v.intr;
    req = 1'b1;
    seen = 1'b0; lat = 0;
    while (!seen && lat < 6) begin
      @(negedge clk);
      lat++;
      if (ack) seen = 1'b1;
    end
    chk({v.name, ".ack_seen"}, 64'(seen), 64'd1);
    chk({v.name, ".ack_lat"},  64'(lat), 64'd1);
    chk({v.name, ".valid"},    64'(valid), 64'd1);
    chk({v.name, ".pc"},       cpc, v.pc);
    chk({v.name, ".inst"},     64'(cinst), 64'(v.inst));
    chk({v.name, ".skip"},     64'(cskip), 64'(v.skip));
    chk({v.name, ".intrNo"},   64'(cintr), 64'(v.intr));
    chk({v.name, ".rf_wen"},   64'(rf_wen), 64'(v.exp_rf_wen));
    chk({v.name, ".rf_waddr"}, 64'(rf_waddr), 64'(v.exp_waddr));
    chk({v.name, ".rf_wdata"}, rf_wdata, v.exp_wdata);
    req = 1'b0;
    @(negedge clk);
    chk({v.name, ".ack_drop"}, 64'({ack, valid, rf_wen}), 64'd0);
    chk({v.name, ".pc_clr"},   cpc, 64'd0);
    chk({v.name, ".instret"},  instret, ret0 + v.exp_ret_inc);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] c0, r0;
    logic [9:0]  mask;
    int          nack;
    vec_t        tv;

    //           name    pc          inst           rd  wen wdata            skip intr  ewen ewaddr ewdata          inc
    vecs[0] = '{"rd5",   64'h8000_0000, 32'h0000_0013, 5,  1, 64'hDEAD_BEEF,  0,  32'd0, 1, 5,  64'hDEAD_BEEF, 1};
    vecs[1] = '{"rd0",   64'h8000_0004, 32'h0000_0013, 0,  1, 64'h1234,       0,  32'd0, 0, 0,  64'd0,         1};
    vecs[2] = '{"intr",  64'h8000_0008, 32'h0000_0073, 3,  1, 64'h5555,       0,  32'd7, 0, 0,  64'd0,         0};
    vecs[3] = '{"nowen", 64'h8000_000c, 32'h0000_0013, 8,  0, 64'h7777,       1,  32'd0, 0, 0,  64'd0,         1};
    vecs[4] = '{"rd31",  64'h8000_0010, 32'h0000_0013, 31, 1, 64'hFFFF_0000_1111_2222, 1, 32'd0, 1, 31, 64'hFFFF_0000_1111_2222, 1};
    vecs[5] = '{"x10",   64'h8000_0014, 32'h0000_0013, 10, 1, 64'd42,         0,  32'd0, 1, 10, 64'd42,        1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.ack_valid", 64'({ack, valid, rf_wen, halt}), 64'd0);
    chk("rst.cycle",     cycle, 64'd0);
    chk("rst.instret",   instret, 64'd0);
    chk("rst.halt_code", halt_code, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("cycle.first", cycle, 64'd1);
    c0 = cycle;
    repeat (5) @(negedge clk);
    chk("cycle.delta", cycle - c0, 64'd5);

    foreach (vecs[i]) commit(vecs[i]);

    // Back-to-back throughput with req held high
    pc = 64'h100; inst = 32'h13; rd = 5'd1; rd_wen = 1'b1; rd_wdata = 64'd1;
    skip = 1'b0; intr = '0;
    r0 = instret; mask = '0;
    req = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (ack) mask[i] = 1'b1;
    end
    req = 1'b0;
    repeat (2) @(negedge clk);
    chk("tput.ack_mask", 64'(mask), 64'b00_1001_0010);
    chk("tput.instret",  instret - r0, 64'd3);

    // instret wrap
    force dut.u_cnt.instret_q = '1;
    #1 release dut.u_cnt.instret_q;
    @(negedge clk);
    tv = vecs[0]; tv.name = "wrap"; tv.exp_ret_inc = 64'd1;
    commit(tv);
    chk("wrap.instret_zero", instret, 64'd0);

    // Async reset in the middle of ACK
    pc = 64'h200; rd = 5'd7; rd_wen = 1'b1; rd_wdata = 64'h99;
    req = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mrst.ack_valid_wen", 64'({ack, valid, rf_wen}), 64'd0);
    chk("mrst.pc_wdata",      cpc | rf_wdata, 64'd0);
    chk("mrst.counters",      cycle | instret, 64'd0);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Trap: a0=42 then trap instruction halts with code 42
    commit(vecs[5]);
    chk("trap.pre_halt", 64'(halt), 64'd0);
    tv = '{"trap", 64'h8000_0100, 32'h0000_006b, 0, 0, 64'd0, 0, 32'd0, 0, 0, 64'd0, 1};
    commit(tv);
    chk("trap.halt",      64'(halt), 64'd1);
    chk("trap.halt_code", halt_code, 64'd42);
    c0 = cycle; nack = 0;
    pc = 64'h300; inst = 32'h13; rd = 5'd10; rd_wen = 1'b1; rd_wdata = 64'd5;
    req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack || rf_wen) nack++;
    end
    req = 1'b0;
    chk("halt.no_ack",    64'(nack), 64'd0);
    chk("halt.cycle_run", cycle - c0, 64'd6);
    chk("halt.sticky",    {63'd0, halt}, 64'd1);
    chk("halt.code_hold", halt_code, 64'd42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
